aibcr3pnr_rstseq: RTL and testbench

Staged reset-release sequencer for one clock domain.
- Synchronizes the async input reset with assert-async / deassert-sync behaviour, using a 3-flop ulvt bit synchronizer with data_in tied high.
- Releases NUM_STAGES downstream active-low resets in fixed order, from index 0 upward.
- Between stages it waits for a per-stage acknowledge (PLL lock, calibration done, etc.), then for a programmable gap.
- Provides a software re-sequence request, an ack-timeout error flag, and scan bypass.

---
 rtl/aibcr3pnr_rstseq.sv | 170 +++++++++++++++++
 tb/tb_aibcr3pnr_rstseq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/aibcr3pnr_rstseq.sv
// Staged reset-release sequencer: synchronizes the incoming reset, then releases
// NUM_STAGES active-low resets in index order, gated by per-stage acks and a gap.
module aibcr3pnr_rstseq #(
   parameter int NUM_STAGES  = 4,
   parameter int CNT_WIDTH   = 8,
   parameter int HOLD_CYC    = 8,
   parameter int STAGE_DLY   = 16,
   parameter int ACK_TIMEOUT = 200
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          scan_mode_n,
   input  logic                          rst_n_bypass,
   input  logic                          sw_rst_req,
   input  logic [NUM_STAGES-1:0]         stage_ack,
   output logic [NUM_STAGES-1:0]         rst_n_out,
   output logic                          seq_done,
   output logic                          seq_err,
   output logic [$clog2(NUM_STAGES)-1:0] err_stage
);

   localparam int IDX_W = $clog2(NUM_STAGES);

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYC - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_DLY - 1);
   localparam logic [CNT_WIDTH-1:0] ACK_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_STAGES - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);

   typedef enum logic [2:0] {
      HOLD     = 3'd0,
      WAIT_ACK = 3'd1,
      GAP      = 3'd2,
      DONE     = 3'd3,
      ERR      = 3'd4
   } state_t;

   logic sync_rst_n;
   logic sync_p0, sync_p1, sync_p2;
   logic rst_int_n;

   state_t                  state, state_d;
   logic [CNT_WIDTH-1:0]    count, count_d;
   logic [IDX_W-1:0]        idx, idx_d;
   logic [NUM_STAGES-1:0]   rel, rel_d;
   logic                    done_r, done_d;
   logic                    err_r, err_d;
   logic [IDX_W-1:0]        err_idx, err_idx_d;

   // In scan the bypass reset also drives the synchronizer so the FSM is controllable.
   assign sync_rst_n = scan_mode_n ? rst_n : rst_n_bypass;

   // Stage boundary: 3-flop reset synchronizer, data tied high
   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= 1'b1;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign rst_int_n = sync_p2;

   // Stage boundary: sequencer state register
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state   <= HOLD;
         count   <= '0;
         idx     <= '0;
         rel     <= '0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         err_idx <= '0;
      end else begin
         state   <= state_d;
         count   <= count_d;
         idx     <= idx_d;
         rel     <= rel_d;
         done_r  <= done_d;
         err_r   <= err_d;
         err_idx <= err_idx_d;
      end
   end

   always_comb begin
      state_d   = state;
      count_d   = count;
      idx_d     = idx;
      rel_d     = rel;
      done_d    = done_r;
      err_d     = err_r;
      err_idx_d = err_idx;

      if (sw_rst_req) begin
         state_d   = HOLD;
         count_d   = '0;
         idx_d     = '0;
         rel_d     = '0;
         done_d    = 1'b0;
         err_d     = 1'b0;
         err_idx_d = '0;
      end else begin
         unique case (state)
            HOLD: begin
               if (count == HOLD_LAST) begin
                  rel_d[0] = 1'b1;
                  idx_d    = '0;
                  count_d  = '0;
                  state_d  = WAIT_ACK;
               end else begin
                  count_d = count + 1'b1;
               end
            end
            WAIT_ACK: begin
               if (stage_ack[idx]) begin
                  count_d = '0;
                  if (idx == IDX_LAST) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     state_d = GAP;
                  end
               end else if ((ACK_TIMEOUT != 0) && (count == ACK_LAST)) begin
                  err_d     = 1'b1;
                  err_idx_d = idx;
                  state_d   = ERR;
               end else if (ACK_TIMEOUT != 0) begin
                  // With the timeout disabled the counter parks instead of wrapping.
                  count_d = count + 1'b1;
               end
            end
            GAP: begin
               if (count == GAP_LAST) begin
                  idx_d   = idx + IDX_ONE;
                  count_d = '0;
                  state_d = WAIT_ACK;
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (IDX_W'(i) == idx_d) rel_d[i] = 1'b1;
                  end
               end else begin
                  count_d = count + 1'b1;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            ERR: begin
               state_d = ERR;
            end
            default: begin
               state_d = HOLD;
               count_d = '0;
               idx_d   = '0;
               rel_d   = '0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   assign rst_n_out = scan_mode_n ? rel : {NUM_STAGES{rst_n_bypass}};
   assign seq_done  = scan_mode_n ? done_r : rst_n_bypass;
   assign seq_err   = scan_mode_n & err_r;
   assign err_stage = err_idx;

endmodule

// File: tb/tb_aibcr3pnr_rstseq.sv
// Directed bench for aibcr3pnr_rstseq: release timing, ack timeout, software
// re-sequence, async reset, scan bypass and a timeout-disabled instance.
module tb_aibcr3pnr_rstseq;

   logic       clk = 1'b0;
   logic       rst_n, scan_mode_n, rst_n_bypass, sw_rst_req;
   logic [3:0] stage_ack, stage_ack2;
   logic [3:0] rst_n_out, rst_n_out2;
   logic       seq_done, seq_err, seq_done2, seq_err2;
   logic [1:0] err_stage, err_stage2;

   int pass_cnt = 0;
   int total    = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   aibcr3pnr_rstseq dut (
      .clk(clk), .rst_n(rst_n), .scan_mode_n(scan_mode_n), .rst_n_bypass(rst_n_bypass),
      .sw_rst_req(sw_rst_req), .stage_ack(stage_ack), .rst_n_out(rst_n_out),
      .seq_done(seq_done), .seq_err(seq_err), .err_stage(err_stage)
   );

   aibcr3pnr_rstseq #(.ACK_TIMEOUT(0)) dut_nto (
      .clk(clk), .rst_n(rst_n), .scan_mode_n(scan_mode_n), .rst_n_bypass(rst_n_bypass),
      .sw_rst_req(sw_rst_req), .stage_ack(stage_ack2), .rst_n_out(rst_n_out2),
      .seq_done(seq_done2), .seq_err(seq_err2), .err_stage(err_stage2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      rst_n        = 1'b0;
      scan_mode_n  = 1'b1;
      rst_n_bypass = 1'b1;
      sw_rst_req   = 1'b0;
      stage_ack    = 4'hF;
      stage_ack2   = 4'h0;
      step(); step(); step();
      chk("reset_out",   rst_n_out, 4'h0);
      chk("reset_done",  seq_done,  1'b0);
      chk("reset_err",   seq_err,   1'b0);
      chk("reset_stage", err_stage, 2'd0);

      // Test 1: nominal sequence, rst_n rises just after edge 0
      rst_n = 1'b1; cyc = 0;
      step_to(10); chk("t1_e10", rst_n_out, 4'b0000);
      step_to(11); chk("t1_e11", rst_n_out, 4'b0001);
      step_to(27); chk("t1_e27", rst_n_out, 4'b0001);
      step_to(28); chk("t1_e28", rst_n_out, 4'b0011);
      step_to(45); chk("t1_e45", rst_n_out, 4'b0111);
      step_to(62); chk("t1_e62", rst_n_out, 4'b1111);
      chk("t1_done62", seq_done, 1'b0);
      step_to(63); chk("t1_done63", seq_done, 1'b1);
      chk("t1_err", seq_err, 1'b0);
      stage_ack = 4'h0;
      step(); chk("t1_ackdrop", {seq_done, rst_n_out}, 5'h1F);

      // Test 2: stage 1 never acks -> timeout at edge 228
      stage_ack = 4'b1101;
      rst_n = 1'b0; step(); step();
      rst_n = 1'b1; cyc = 0;
      step_to(28);  chk("t2_e28", rst_n_out, 4'b0011);
      step_to(227); chk("t2_err227", seq_err, 1'b0);
      step_to(228); chk("t2_err228", seq_err, 1'b1);
      chk("t2_stage", err_stage, 2'd1);
      chk("t2_done",  seq_done,  1'b0);
      chk("t2_out",   rst_n_out, 4'b0011);
      step_to(240); chk("t2_sticky", {seq_err, rst_n_out}, 5'h13);
      sw_rst_req = 1'b1;
      step(); chk("t2_sw_out", rst_n_out, 4'h0);
      chk("t2_sw_err", seq_err, 1'b0);
      sw_rst_req = 1'b0; stage_ack = 4'hF; cyc = 0;
      step_to(7);  chk("t2_rerun7", rst_n_out, 4'b0000);
      step_to(8);  chk("t2_rerun8", rst_n_out, 4'b0001);
      step_to(59); chk("t2_done59", seq_done, 1'b0);
      step_to(60); chk("t2_done60", seq_done, 1'b1);

      // Test 3: sw_rst_req held 5 cycles while in DONE
      sw_rst_req = 1'b1;
      step(); chk("t3_sw_out", rst_n_out, 4'h0);
      chk("t3_sw_done", seq_done, 1'b0);
      step(); step(); step(); step();
      chk("t3_held", rst_n_out, 4'h0);
      sw_rst_req = 1'b0; cyc = 0;
      step_to(7);  chk("t3_e7", rst_n_out, 4'b0000);
      step_to(8);  chk("t3_e8", rst_n_out, 4'b0001);
      step_to(60); chk("t3_done", seq_done, 1'b1);

      // Test 4: async rst_n mid-GAP
      sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0; cyc = 0;
      step_to(30); chk("t4_gap", rst_n_out, 4'b0011);
      #2 rst_n = 1'b0;
      #1 chk("t4_async", rst_n_out, 4'h0);
      step(); step();
      rst_n = 1'b1; cyc = 0;
      step_to(10); chk("t4_e10", rst_n_out, 4'b0000);
      step_to(11); chk("t4_e11", rst_n_out, 4'b0001);
      step_to(28); chk("t4_e28", rst_n_out, 4'b0011);
      step_to(62); chk("t4_e62", rst_n_out, 4'b1111);
      step_to(63); chk("t4_done", seq_done, 1'b1);

      // Test 6: sw_rst_req and ack together in WAIT_ACK
      sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0; cyc = 0;
      step_to(8); chk("t6_wait", rst_n_out, 4'b0001);
      sw_rst_req = 1'b1;
      step(); chk("t6_win_out", rst_n_out, 4'h0);
      chk("t6_win_done", seq_done, 1'b0);
      sw_rst_req = 1'b0; cyc = 0;
      step_to(7); chk("t6_e7", rst_n_out, 4'b0000);
      step_to(8); chk("t6_e8", rst_n_out, 4'b0001);
      step_to(1010);
      chk("t6_nto_err",  seq_err2,   1'b0);
      chk("t6_nto_out",  rst_n_out2, 4'b0001);
      chk("t6_nto_done", seq_done2,  1'b0);

      // Test 5: scan bypass is purely combinational
      scan_mode_n = 1'b0; rst_n_bypass = 1'b0;
      #1 chk("t5_out0", rst_n_out, 4'h0);
      chk("t5_done0", seq_done, 1'b0);
      rst_n_bypass = 1'b1;
      #1 chk("t5_out1", rst_n_out, 4'hF);
      chk("t5_done1", seq_done, 1'b1);
      chk("t5_err", seq_err, 1'b0);
      rst_n = 1'b0;
      #1 chk("t5_rstn", rst_n_out, 4'hF);
      rst_n_bypass = 1'b0;
      #1 chk("t5_out0b", rst_n_out, 4'h0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
